// File: rtl/gmii_rx.sv
// rtl/gmii_rx.sv - GMII receive framer: strips preamble/SFD, emits payload bytes with sof/eof/err/len.
module gmii_rx #(
    parameter int unsigned MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    input  logic [7:0]  i_rxd,
    output logic [7:0]  o_data,
    output logic        o_dv,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_err,
    output logic [15:0] o_len,
    output logic        o_drop
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    state_t      state_q;
    logic        dv_q, er_q;
    logic [7:0]  rxd_q;
    logic        stage_vld_q;
    logic [7:0]  hold_q;
    logic        hold_vld_q;
    logic        first_q;
    logic        err_q;
    logic [15:0] cnt_q;

    logic [15:0] cnt_d;
    logic        too_long;

    assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign too_long = ({1'b0, cnt_q} > 17'(MAX_LEN));

    // stage_vld_q keeps the reset value of dv_q from being mistaken for a real
    // dv-low, so a frame in flight at reset release is swallowed by DROP.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= DROP;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            rxd_q       <= 8'h00;
            stage_vld_q <= 1'b0;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 16'h0000;
            o_data      <= 8'h00;
            o_dv        <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_err       <= 1'b0;
            o_len       <= 16'h0000;
            o_drop      <= 1'b0;
        end else begin
            dv_q        <= i_rx_dv;
            er_q        <= i_rx_er;
            rxd_q       <= i_rxd;
            stage_vld_q <= 1'b1;

            o_data <= 8'h00;
            o_dv   <= 1'b0;
            o_sof  <= 1'b0;
            o_eof  <= 1'b0;
            o_err  <= 1'b0;
            o_len  <= 16'h0000;
            o_drop <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (dv_q) begin
                        if (er_q) begin
                            state_q <= DROP;
                            o_drop  <= 1'b1;
                        end else if (rxd_q == PRE_BYTE) begin
                            state_q <= PREAMBLE;
                        end else if (rxd_q == SFD_BYTE) begin
                            state_q    <= DATA;
                            cnt_q      <= 16'h0000;
                            hold_vld_q <= 1'b0;
                            first_q    <= 1'b1;
                            err_q      <= 1'b0;
                        end else begin
                            state_q <= DROP;
                            o_drop  <= 1'b1;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!dv_q) begin
                        state_q <= IDLE;
                        o_drop  <= 1'b1;
                    end else if (er_q) begin
                        state_q <= DROP;
                        o_drop  <= 1'b1;
                    end else if (rxd_q == SFD_BYTE) begin
                        state_q    <= DATA;
                        cnt_q      <= 16'h0000;
                        hold_vld_q <= 1'b0;
                        first_q    <= 1'b1;
                        err_q      <= 1'b0;
                    end else if (rxd_q != PRE_BYTE) begin
                        state_q <= DROP;
                        o_drop  <= 1'b1;
                    end
                end
                DATA: begin
                    if (dv_q) begin
                        if (hold_vld_q) begin
                            o_dv    <= 1'b1;
                            o_data  <= hold_q;
                            o_sof   <= first_q;
                            first_q <= 1'b0;
                        end
                        hold_q     <= rxd_q;
                        hold_vld_q <= 1'b1;
                        cnt_q      <= cnt_d;
                        if (er_q) err_q <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        hold_vld_q <= 1'b0;
                        if (hold_vld_q) begin
                            o_dv   <= 1'b1;
                            o_data <= hold_q;
                            o_sof  <= first_q;
                            o_eof  <= 1'b1;
                            o_len  <= cnt_q;
                            o_err  <= err_q | too_long;
                        end else begin
                            o_drop <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (stage_vld_q && !dv_q) state_q <= IDLE;
                end
                default: state_q <= DROP;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx.sv
// tb/tb_gmii_rx.sv - directed self-checking bench for gmii_rx.
module tb_gmii_rx;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_rx_dv, i_rx_er;
    logic [7:0]  i_rxd;
    logic [7:0]  o_data;
    logic        o_dv, o_sof, o_eof, o_err, o_drop;
    logic [15:0] o_len;

    gmii_rx #(.MAX_LEN(1522)) dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_rx_dv(i_rx_dv), .i_rx_er(i_rx_er), .i_rxd(i_rxd),
        .o_data(o_data), .o_dv(o_dv), .o_sof(o_sof), .o_eof(o_eof), .o_err(o_err),
        .o_len(o_len), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    int n_eval = 0;
    int n_fail = 0;
    int cyc = 0;

    // capture of DUT beats
    logic [7:0] cap_data [2048];
    int         cap_cyc  [2048];
    int nb, n_sof, n_eof, n_drop, zero_viol, eof_idx;
    logic first_sof, last_err;
    logic [15:0] last_len;

    // expected beats built from stimulus
    logic [7:0] exp_data [2048];
    int         exp_cyc  [2048];
    int exp_n;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_drop) n_drop++;
        if (o_dv) begin
            if (nb < 2048) begin
                cap_data[nb] = o_data;
                cap_cyc[nb]  = cyc;
            end
            if (nb == 0) first_sof = o_sof;
            if (o_sof) n_sof++;
            if (o_eof) begin
                n_eof++;
                eof_idx  = nb;
                last_len = o_len;
                last_err = o_err;
            end
            nb++;
        end else if ({o_data, o_sof, o_eof, o_err, o_len} != '0) begin
            zero_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        nb = 0; n_sof = 0; n_eof = 0; n_drop = 0; zero_viol = 0; eof_idx = -1;
        first_sof = 1'b0; last_err = 1'b0; last_len = 16'h0; exp_n = 0;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #2;
        i_rx_dv = dv;
        i_rx_er = er;
        i_rxd   = d;
    endtask

    task automatic push_exp(input logic [7:0] d);
        if (exp_n < 2048) begin
            exp_data[exp_n] = d;
            exp_cyc[exp_n]  = cyc;
        end
        exp_n++;
    endtask

    task automatic send_frame(input int npre, input int nbytes, input int er_idx,
                              input logic [7:0] base, input int gap);
        logic [7:0] d;
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < nbytes; i++) begin
            d = base + 8'(i);
            drive(1'b1, (i == er_idx), d);
            push_exp(d);
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_frames(input string tag, input int nfr, input int len,
                                input logic err, input int drops);
        int bad;
        bad = 0;
        for (int i = 0; i < nb && i < exp_n && i < 2048; i++)
            if (cap_data[i] !== exp_data[i] || cap_cyc[i] - exp_cyc[i] != 3) bad++;
        chk({tag, "_beats"}, nb, exp_n);
        chk({tag, "_data_latency"}, bad, 0);
        chk({tag, "_sof_count"}, n_sof, nfr);
        chk({tag, "_eof_count"}, n_eof, nfr);
        chk({tag, "_drops"}, n_drop, drops);
        chk({tag, "_idle_zero"}, zero_viol, 0);
        if (nfr > 0 && nb > 0) begin
            chk({tag, "_sof_first"}, first_sof, 1);
            chk({tag, "_eof_last"}, eof_idx, nb - 1);
            chk({tag, "_len"}, last_len, len);
            chk({tag, "_err"}, last_err, err);
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_rx_dv = 1'b0; i_rx_er = 1'b0; i_rxd = 8'h00;
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {o_data, o_dv, o_sof, o_eof, o_err, o_len, o_drop}, 0);
        i_reset_n = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 8'h00);

        clear_mon();
        send_frame(7, 64, -1, 8'h01, 5);
        check_frames("frame64", 1, 64, 1'b0, 0);

        clear_mon();
        send_frame(0, 1, -1, 8'hAB, 5);
        check_frames("frame1", 1, 1, 1'b0, 0);
        chk("frame1_byte", cap_data[0], 8'hAB);

        clear_mon();
        send_frame(1, 0, -1, 8'h00, 5);
        check_frames("zero_payload", 0, 0, 1'b0, 1);

        clear_mon();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h12);
        repeat (10) drive(1'b1, 1'b0, 8'h33);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        send_frame(1, 4, -1, 8'h90, 5);
        check_frames("bad_preamble", 1, 4, 1'b0, 1);

        clear_mon();
        send_frame(7, 20, 4, 8'h20, 5);
        check_frames("rx_er", 1, 20, 1'b1, 0);

        clear_mon();
        send_frame(2, 3, -1, 8'h40, 1);
        send_frame(2, 5, -1, 8'h50, 5);
        check_frames("one_gap", 2, 5, 1'b0, 0);

        clear_mon();
        send_frame(7, 1600, -1, 8'h00, 5);
        check_frames("len1600", 1, 1600, 1'b1, 0);

        clear_mon();
        send_frame(7, 1522, -1, 8'h10, 5);
        check_frames("len1522", 1, 1522, 1'b0, 0);

        repeat (3) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'hE0 + 8'(i));
        #1 i_reset_n = 1'b0;
        #1 chk("reset_mid_outputs", {o_data, o_dv, o_sof, o_eof, o_err, o_len, o_drop}, 0);
        clear_mon();
        drive(1'b1, 1'b0, 8'hE6);
        #1 i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hE7 + 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        send_frame(2, 8, -1, 8'hC0, 5);
        check_frames("reset_recover", 1, 8, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
